// File: rtl/vip_scale_pkg.sv
// Shared types and constants for the vip_scale configuration sequencer.
package vip_scale_pkg;
  localparam int SIZE_W = 12;
  localparam int K_W    = 16;
  localparam int FRAC_W = 8;
  localparam logic [K_W-1:0] K_SAT = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_DIV_H,
    ST_DIV_V,
    ST_PEND
  } state_e;

  typedef struct packed {
    logic [SIZE_W-1:0] s_width;
    logic [SIZE_W-1:0] s_height;
    logic [SIZE_W-1:0] t_width;
    logic [SIZE_W-1:0] t_height;
  } geom_t;

  // Elaboration-time Q8.8 factor, used for the reset values only.
  function automatic logic [K_W-1:0] k_calc(input int s, input int t, input bit rnd);
    int q;
    q = ((s << FRAC_W) + (rnd ? t / 2 : 0)) / t;
    return (q > int'(K_SAT)) ? K_SAT : K_W'(q);
  endfunction
endpackage

// File: rtl/vip_scale_cfg_if.sv
// Host-side geometry request channel: valid/ready handshake plus reject pulse.
interface vip_scale_cfg_if;
  import vip_scale_pkg::*;

  logic              cfg_valid;
  logic              cfg_ready;
  logic              cfg_err;
  logic [SIZE_W-1:0] cfg_s_width;
  logic [SIZE_W-1:0] cfg_s_height;
  logic [SIZE_W-1:0] cfg_t_width;
  logic [SIZE_W-1:0] cfg_t_height;

  modport master (
    output cfg_valid, cfg_s_width, cfg_s_height, cfg_t_width, cfg_t_height,
    input  cfg_ready, cfg_err
  );

  modport slave (
    input  cfg_valid, cfg_s_width, cfg_s_height, cfg_t_width, cfg_t_height,
    output cfg_ready, cfg_err
  );
endinterface

// File: rtl/vip_scale_div.sv
// Radix-2 restoring divider: one quotient bit per cycle for DW cycles after start.
// done/quo are the last-step indication and the quotient as it will be after this cycle.
module vip_scale_div #(
  parameter int DW = 20,
  parameter int SW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [DW-1:0] dividend,
  input  logic [SW-1:0] divisor,
  output logic          done,
  output logic [DW-1:0] quo
);
  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0] q_q, q_d;
  logic [SW-1:0] r_q, r_d, r_nxt, r_sub;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW:0]   r_sh;
  logic          ge;

  always_comb begin
    r_sh  = {r_q, q_q[DW-1]};
    ge    = (r_sh >= {1'b0, divisor});
    // remainder after a successful subtract is below the divisor, so it fits SW bits
    r_sub = SW'(r_sh - {1'b0, divisor});
    r_nxt = ge ? r_sub : r_sh[SW-1:0];
    quo   = {q_q[DW-2:0], ge};
    done  = (cnt_q == CW'(1));
    q_d   = q_q;
    r_d   = r_q;
    cnt_d = cnt_q;
    if (start) begin
      q_d   = dividend;
      r_d   = '0;
      cnt_d = CW'(DW);
    end else if (cnt_q != '0) begin
      q_d   = quo;
      r_d   = r_nxt;
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q   <= '0;
      r_q   <= '0;
      cnt_q <= '0;
    end else begin
      q_q   <= q_d;
      r_q   <= r_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/vip_scale_cfg.sv
// Geometry sequencer: validate, compute Q8.8 h/v factors, apply all six at the next vs rise.
// VIP_SCALE_CFG_ROUND_EN selects round-to-nearest division (one extra divider cycle).
module vip_scale_cfg
  import vip_scale_pkg::*;
#(
  parameter int DEF_S_WIDTH  = 1280,
  parameter int DEF_S_HEIGHT = 720,
  parameter int DEF_T_WIDTH  = 640,
  parameter int DEF_T_HEIGHT = 360,
`ifdef VIP_SCALE_CFG_ROUND_EN
  parameter int DIV_W        = 21
`else
  parameter int DIV_W        = 20
`endif
) (
  input  logic              pixel_clk,
  input  logic              sys_rst,
  input  logic              vs,
  vip_scale_cfg_if.slave    cfg,
  output logic [SIZE_W-1:0] s_width,
  output logic [SIZE_W-1:0] s_height,
  output logic [SIZE_W-1:0] t_width,
  output logic [SIZE_W-1:0] t_height,
  output logic [K_W-1:0]    h_scale_k,
  output logic [K_W-1:0]    v_scale_k,
  output logic              cfg_applied,
  output logic              busy
);
`ifdef VIP_SCALE_CFG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam logic [K_W-1:0] H_K_DEF = k_calc(DEF_S_WIDTH, DEF_T_WIDTH, RND);
  localparam logic [K_W-1:0] V_K_DEF = k_calc(DEF_S_HEIGHT, DEF_T_HEIGHT, RND);
  localparam geom_t GEOM_DEF = '{
    s_width:  SIZE_W'(DEF_S_WIDTH),
    s_height: SIZE_W'(DEF_S_HEIGHT),
    t_width:  SIZE_W'(DEF_T_WIDTH),
    t_height: SIZE_W'(DEF_T_HEIGHT)
  };

  state_e         state_q, state_d;
  geom_t          geom_q, geom_d, out_q, out_d;
  logic [K_W-1:0] hk_sh_q, hk_sh_d, vk_sh_q, vk_sh_d, hk_q, hk_d, vk_q, vk_d;
  logic           ready_q, ready_d, busy_q, busy_d, err_q, err_d, app_q, app_d, vs_q, vs_d;

  logic              div_start, div_done, geom_bad, rise;
  logic [DIV_W-1:0]  div_dvd, div_quo, dvd_h, dvd_v;
  logic [SIZE_W-1:0] div_dvs;
  logic [K_W-1:0]    div_k;

  // Dividends for both axes; the divider loads h at CHECK and v on the last h step.
  always_comb begin
    dvd_h = DIV_W'({geom_q.s_width,  {FRAC_W{1'b0}}});
    dvd_v = DIV_W'({geom_q.s_height, {FRAC_W{1'b0}}});
`ifdef VIP_SCALE_CFG_ROUND_EN
    dvd_h = dvd_h + DIV_W'(geom_q.t_width  >> 1);
    dvd_v = dvd_v + DIV_W'(geom_q.t_height >> 1);
`endif
    div_dvd = (state_q == ST_CHECK) ? dvd_h : dvd_v;
    div_dvs = (state_q == ST_DIV_V) ? geom_q.t_height : geom_q.t_width;
    div_k   = (div_quo > DIV_W'(K_SAT)) ? K_SAT : div_quo[K_W-1:0];
  end

  vip_scale_div #(.DW(DIV_W), .SW(SIZE_W)) u_div (
    .clk      (pixel_clk),
    .rst      (sys_rst),
    .start    (div_start),
    .dividend (div_dvd),
    .divisor  (div_dvs),
    .done     (div_done),
    .quo      (div_quo)
  );

  always_comb begin
    state_d   = state_q;
    geom_d    = geom_q;
    hk_sh_d   = hk_sh_q;
    vk_sh_d   = vk_sh_q;
    out_d     = out_q;
    hk_d      = hk_q;
    vk_d      = vk_q;
    err_d     = 1'b0;
    app_d     = 1'b0;
    vs_d      = vs;
    div_start = 1'b0;
    rise      = vs & ~vs_q;
    geom_bad  = (geom_q.s_width == '0) || (geom_q.s_height == '0) ||
                (geom_q.t_width == '0) || (geom_q.t_height == '0) ||
                (geom_q.t_width > geom_q.s_width) || (geom_q.t_height > geom_q.s_height);
    case (state_q)
      ST_IDLE: begin
        if (cfg.cfg_valid && ready_q) begin
          geom_d.s_width  = cfg.cfg_s_width;
          geom_d.s_height = cfg.cfg_s_height;
          geom_d.t_width  = cfg.cfg_t_width;
          geom_d.t_height = cfg.cfg_t_height;
          state_d         = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (geom_bad) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          div_start = 1'b1;
          state_d   = ST_DIV_H;
        end
      end
      ST_DIV_H: begin
        if (div_done) begin
          hk_sh_d   = div_k;
          div_start = 1'b1;
          state_d   = ST_DIV_V;
        end
      end
      ST_DIV_V: begin
        if (div_done) begin
          vk_sh_d = div_k;
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        // only a frame start seen here may change the live geometry
        if (rise) begin
          out_d   = geom_q;
          hk_d    = hk_sh_q;
          vk_d    = vk_sh_q;
          app_d   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
      geom_q  <= '0;
      hk_sh_q <= '0;
      vk_sh_q <= '0;
      out_q   <= GEOM_DEF;
      hk_q    <= H_K_DEF;
      vk_q    <= V_K_DEF;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      app_q   <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      geom_q  <= geom_d;
      hk_sh_q <= hk_sh_d;
      vk_sh_q <= vk_sh_d;
      out_q   <= out_d;
      hk_q    <= hk_d;
      vk_q    <= vk_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      app_q   <= app_d;
      vs_q    <= vs_d;
    end
  end

  assign cfg.cfg_ready = ready_q;
  assign cfg.cfg_err   = err_q;
  assign s_width       = out_q.s_width;
  assign s_height      = out_q.s_height;
  assign t_width       = out_q.t_width;
  assign t_height      = out_q.t_height;
  assign h_scale_k     = hk_q;
  assign v_scale_k     = vk_q;
  assign cfg_applied   = app_q;
  assign busy          = busy_q;
endmodule

// File: tb/tb_vip_scale_cfg.sv
// Directed + randomized bench for vip_scale_cfg against an arithmetic reference model.
`timescale 1ns/1ps
module tb_vip_scale_cfg;
  import vip_scale_pkg::*;

`ifdef VIP_SCALE_CFG_ROUND_EN
  localparam int  DW  = 21;
  localparam bit  RND = 1'b1;
`else
  localparam int  DW  = 20;
  localparam bit  RND = 1'b0;
`endif
  // accept = cycle 0, CHECK = 1, two DW-cycle divisions, then PEND
  localparam int PEND_CYC = 2 * DW + 2;

  logic              pixel_clk = 1'b0;
  logic              sys_rst;
  logic              vs;
  logic [SIZE_W-1:0] s_width, s_height, t_width, t_height;
  logic [K_W-1:0]    h_scale_k, v_scale_k;
  logic              cfg_applied, busy;

  vip_scale_cfg_if cif ();

  vip_scale_cfg dut (
    .pixel_clk   (pixel_clk),
    .sys_rst     (sys_rst),
    .vs          (vs),
    .cfg         (cif),
    .s_width     (s_width),
    .s_height    (s_height),
    .t_width     (t_width),
    .t_height    (t_height),
    .h_scale_k   (h_scale_k),
    .v_scale_k   (v_scale_k),
    .cfg_applied (cfg_applied),
    .busy        (busy)
  );

  always #5 pixel_clk = ~pixel_clk;

  int checks = 0;
  int errors = 0;
  int ex_sw, ex_sh, ex_tw, ex_th, ex_hk, ex_vk;

  function automatic int kmodel(input int s, input int t);
    int n;
    n = s * 256;
    if (RND) n = n + t / 2;
    return (n / t > 65535) ? 65535 : n / t;
  endfunction

  function automatic bit geom_ok(input int sw, input int sh, input int tw, input int th);
    return (sw > 0) && (sh > 0) && (tw > 0) && (th > 0) && (tw <= sw) && (th <= sh);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_live(input string tag);
    chk({tag, "_s_width"},  s_width,   ex_sw);
    chk({tag, "_s_height"}, s_height,  ex_sh);
    chk({tag, "_t_width"},  t_width,   ex_tw);
    chk({tag, "_t_height"}, t_height,  ex_th);
    chk({tag, "_h_k"},      h_scale_k, ex_hk);
    chk({tag, "_v_k"},      v_scale_k, ex_vk);
  endtask

  task automatic set_defaults();
    ex_sw = 1280; ex_sh = 720; ex_tw = 640; ex_th = 360; ex_hk = 512; ex_vk = 512;
  endtask

  // Offer a geometry at the current negedge (cycle 0 of the transaction).
  task automatic offer(input int sw, input int sh, input int tw, input int th);
    cif.cfg_valid    = 1'b1;
    cif.cfg_s_width  = SIZE_W'(sw);
    cif.cfg_s_height = SIZE_W'(sh);
    cif.cfg_t_width  = SIZE_W'(tw);
    cif.cfg_t_height = SIZE_W'(th);
    vs               = 1'b0;
    chk("ready_at_offer", cif.cfg_ready, 1);
  endtask

  // Valid geometry: vs rises at cycle rise1 and, if that was too early, again after PEND.
  task automatic run_cfg(input int sw, input int sh, input int tw, input int th,
                         input int rise1, input bit hold);
    int rise2, app;
    rise2 = (rise1 >= PEND_CYC) ? -1 : PEND_CYC + 3;
    app   = ((rise1 >= PEND_CYC) ? rise1 : rise2) + 1;
    offer(sw, sh, tw, th);
    @(negedge pixel_clk);
    if (!hold) cif.cfg_valid = 1'b0;
    for (int c = 1; c < app; c++) begin
      chk("applied_early", cfg_applied, 0);
      chk("ready_busy",    cif.cfg_ready, 0);
      chk("busy",          busy, 1);
      chk("err_on_good",   cif.cfg_err, 0);
      chk("hold_h_k",      h_scale_k, ex_hk);
      chk("hold_s_width",  s_width, ex_sw);
      vs = (c == rise1) || (c == rise2);
      @(negedge pixel_clk);
    end
    vs    = 1'b0;
    ex_sw = sw; ex_sh = sh; ex_tw = tw; ex_th = th;
    ex_hk = kmodel(sw, tw);
    ex_vk = kmodel(sh, th);
    chk("applied_pulse", cfg_applied, 1);
    chk("ready_after",   cif.cfg_ready, 1);
    chk("busy_after",    busy, 0);
    chk_live("apply");
  endtask

  task automatic run_bad(input int sw, input int sh, input int tw, input int th);
    offer(sw, sh, tw, th);
    @(negedge pixel_clk);
    cif.cfg_valid = 1'b0;
    chk("bad_c1_err",   cif.cfg_err, 0);
    chk("bad_c1_busy",  busy, 1);
    chk("bad_c1_ready", cif.cfg_ready, 0);
    @(negedge pixel_clk);
    chk("bad_err_pulse", cif.cfg_err, 1);
    chk("bad_busy",      busy, 0);
    chk("bad_ready",     cif.cfg_ready, 1);
    chk("bad_applied",   cfg_applied, 0);
    chk_live("bad_hold");
    @(negedge pixel_clk);
    chk("bad_err_single", cif.cfg_err, 0);
    chk_live("bad_hold2");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int sw, sh, tw, th;
    sys_rst          = 1'b1;
    vs               = 1'b0;
    cif.cfg_valid    = 1'b0;
    cif.cfg_s_width  = '0;
    cif.cfg_s_height = '0;
    cif.cfg_t_width  = '0;
    cif.cfg_t_height = '0;
    set_defaults();
    repeat (3) @(negedge pixel_clk);
    sys_rst = 1'b0;

    chk_live("reset");
    chk("reset_err",     cif.cfg_err, 0);
    chk("reset_applied", cfg_applied, 0);
    chk("reset_busy",    busy, 0);
    chk("reset_ready",   cif.cfg_ready, 1);

    // vs during DIV_H ignored; applies only on the PEND rise
    run_cfg(1280, 720, 640, 360, 20, 1'b0);
    // vs rising on the very first PEND cycle
    run_cfg(1920, 1080, 1280, 720, PEND_CYC, 1'b0);
    chk("k_384_h", h_scale_k, 384);
    chk("k_384_v", v_scale_k, 384);
    // saturation, with a rise on the last DIV_V cycle that must be ignored
    run_cfg(1000, 200, 3, 3, PEND_CYC - 1, 1'b0);
    chk("sat_h", h_scale_k, 16'hFFFF);
`ifdef VIP_SCALE_CFG_ROUND_EN
    chk("third_v", v_scale_k, 17067);
`else
    chk("third_v", v_scale_k, 17066);
`endif

    run_bad(1000, 720, 0, 360);
    run_bad(1280, 720, 640, 800);

    // valid held high throughout: second geometry accepted on the cycle after apply
    run_cfg(1920, 1080, 960, 540, 15, 1'b1);
    run_cfg(800, 600, 400, 300, PEND_CYC + 2, 1'b0);

    for (int i = 0; i < 8; i++) begin
      sw = int'($urandom_range(4095, 1));
      sh = int'($urandom_range(4095, 1));
      tw = int'($urandom_range(sw, 1));
      th = int'($urandom_range(sh, 1));
      case ($urandom_range(3, 0))
        0: tw = 0;
        1: if (sh < 4095) th = sh + 1;
        default: ;
      endcase
      if (geom_ok(sw, sh, tw, th))
        run_cfg(sw, sh, tw, th, int'($urandom_range(PEND_CYC + 4, 2)), 1'b0);
      else
        run_bad(sw, sh, tw, th);
    end

    // reset in the middle of DIV_H
    offer(1920, 1080, 1280, 720);
    @(negedge pixel_clk);
    cif.cfg_valid = 1'b0;
    repeat (11) @(negedge pixel_clk);
    chk("mid_div_busy", busy, 1);
    sys_rst = 1'b1;
    @(negedge pixel_clk);
    sys_rst = 1'b0;
    set_defaults();
    chk_live("rst_mid");
    chk("rst_mid_busy",    busy, 0);
    chk("rst_mid_ready",   cif.cfg_ready, 1);
    chk("rst_mid_applied", cfg_applied, 0);
    chk("rst_mid_err",     cif.cfg_err, 0);
    for (int c = 0; c < 60; c++) begin
      vs = ((c % 10) < 5);
      @(negedge pixel_clk);
      chk("rst_no_apply", cfg_applied, 0);
      chk("rst_h_k",      h_scale_k, 512);
    end
    vs = 1'b0;
    @(negedge pixel_clk);

    run_cfg(640, 480, 320, 240, PEND_CYC, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
